// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcode/funct codes,
// ALU OP codes, FSM state encoding and the registered control-word layout.
// Latency: n/a (definitions only). Backpressure: none.
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU OP codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_EQ  = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_LT  = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Mux select encodings
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_FLAG   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  // Registered control word; pc_write here is the unconditional part only.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] wb_sel;
    logic       halted;
  } ctrl_t;

  // Quiescent word: every strobe low, ALU parked on ADD.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and ZERO in, control strobes out.
// Latency: n/a (wires only). Backpressure: none.
// Ports: master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic [1:0] wb_sel;
  logic       zero_q;    // captured compare flag, feeds write-back source 10
  logic       illegal;
  logic       halted;

  modport master (
    input  opcode, funct, zero,
    output alu_op, alu_src_a, alu_src_b, ext_zero, pc_write, pc_src, iord,
           mem_read, mem_write, ir_write, reg_write, reg_dst, wb_sel, zero_q,
           illegal, halted
  );

  modport slave (
    output opcode, funct, zero,
    input  alu_op, alu_src_a, alu_src_b, ext_zero, pc_write, pc_src, iord,
           mem_read, mem_write, ir_write, reg_write, reg_dst, wb_sel, zero_q,
           illegal, halted
  );
endinterface

// File: rtl/mips_alu_dec.sv
// R-type funct -> ALU OP decoder with a valid flag for supported functs.
// Latency: combinational. Backpressure: none.
// Ports: funct in (6), alu_op out (4), valid out (1).
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_NOR:  alu_op = ALU_NOR;
      FN_SLT:  alu_op = ALU_LT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM driving ALU OP and datapath enables from IR fields and ZERO.
// Latency: R/I 4, lw 5, sw 4, beq/bne/j 3, illegal 2 cycles. Backpressure: none.
// Ports: clk, rst (async, active high), bus (master modport of mips_multicycle_ctrl_if).
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  mips_multicycle_ctrl_if.master bus
);

  state_t     state;
  state_t     nxt;
  ctrl_t      ctrl_q;
  logic       zero_q;
  logic [3:0] r_alu_op;
  logic       r_valid;
  logic       legal;

  mips_alu_dec u_alu_dec (
    .funct  (bus.funct),
    .alu_op (r_alu_op),
    .valid  (r_valid)
  );

  always_comb begin
    legal = 1'b0;
    case (bus.opcode)
      OP_RTYPE: legal = r_valid;
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ANDI, OP_ORI, OP_SLTI, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (!legal) begin
          nxt = ILLEGAL_HALT ? S_HALT : S_FETCH;
        end else begin
          case (bus.opcode)
            OP_LW, OP_SW:                     nxt = S_MEM_ADDR;
            OP_RTYPE:                         nxt = S_R_EXEC;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_I_EXEC;
            OP_BEQ, OP_BNE:                   nxt = S_BRANCH;
            OP_J:                             nxt = S_JUMP;
            default:                          nxt = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR: nxt = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = S_MEM_WB;
      S_R_EXEC:   nxt = S_R_WB;
      S_I_EXEC:   nxt = S_I_WB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_FETCH;
    endcase
  end

  // Control word for the state being entered. Computed from the next state so the
  // outputs come straight from flops yet line up with the state register.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op,
                                       input logic [5:0] fn, input logic [3:0] r_op);
    ctrl_t c;
    c = ctrl_idle();
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_src    = PC_ALU;
        c.pc_write  = 1'b1;
      end
      // PC + (sext(imm) << 2) lands in ALUOut as the branch target.
      S_DECODE:   c.alu_src_b = SRCB_BOFF;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_MDR;
      end
      S_MEM_WR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = r_op;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.wb_sel    = (fn == FN_SLT) ? WB_FLAG : WB_ALUOUT;
      end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        case (op)
          OP_ANDI: begin c.alu_op = ALU_AND; c.ext_zero = 1'b1; end
          OP_ORI:  begin c.alu_op = ALU_OR;  c.ext_zero = 1'b1; end
          OP_SLTI: c.alu_op = ALU_LT;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        c.reg_write = 1'b1;
        c.wb_sel    = (op == OP_SLTI) ? WB_FLAG : WB_ALUOUT;
      end
      S_BRANCH: begin
        c.alu_op    = ALU_EQ;
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.pc_src    = PC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_src   = PC_JUMP;
        c.pc_write = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: c = ctrl_idle();
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ctrl_q <= ctrl_idle();
      zero_q <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl_q <= state_ctrl(nxt, bus.opcode, bus.funct, r_alu_op);
      // LT/EQ results exist only on ZERO; hold them for the write-back cycle.
      if (state == S_R_EXEC || state == S_I_EXEC) begin
        zero_q <= bus.zero;
      end
    end
  end

  assign bus.alu_op    = ctrl_q.alu_op;
  assign bus.alu_src_a = ctrl_q.alu_src_a;
  assign bus.alu_src_b = ctrl_q.alu_src_b;
  assign bus.ext_zero  = ctrl_q.ext_zero;
  assign bus.pc_src    = ctrl_q.pc_src;
  assign bus.iord      = ctrl_q.iord;
  assign bus.mem_read  = ctrl_q.mem_read;
  assign bus.mem_write = ctrl_q.mem_write;
  assign bus.ir_write  = ctrl_q.ir_write;
  assign bus.reg_write = ctrl_q.reg_write;
  assign bus.reg_dst   = ctrl_q.reg_dst;
  assign bus.wb_sel    = ctrl_q.wb_sel;
  assign bus.halted    = ctrl_q.halted;
  assign bus.zero_q    = zero_q;

  // Branch decision is the one path from ZERO straight to a strobe: beq takes on
  // equal, bne on not-equal.
  assign bus.pc_write = ctrl_q.pc_write |
                        ((state == S_BRANCH) && (bus.zero ^ (bus.opcode == OP_BNE)));

  // The opcode is only trustworthy once DECODE is reached, so this pulse is decoded live.
  assign bus.illegal = (state == S_DECODE) && !legal;

endmodule
